// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding, default tap masks and counter sizing for the LFSR stream generator
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCRAMBLE = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] TAPS_W4 = 4'b0111;
    localparam logic [7:0] TAPS_W8 = 8'b10111000;

    // counter wide enough to hold 0..n, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: next Fibonacci LFSR value; fill selects feedback fill or zero fill into the MSB
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   TAPS  = TAPS_W4
) (
    input  logic [WIDTH-1:0] value,
    input  logic             fill,
    output logic [WIDTH-1:0] next_value
);

    assign next_value = {fill ? ^(value & TAPS) : 1'b0, value[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: seed load, scramble, then stream OUT_BITS LSB-first bits over valid/ready.
// Optional LFSR_LOCKUP_GUARD_EN replaces an all-zero seed with all ones and adds o_seed_fixed.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] TAPS            = 4'b0111,
    parameter int               SCRAMBLE_CYCLES = 8,
    parameter int               OUT_BITS        = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_continuous,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_out,
    input  logic             i_ready,
    output logic             o_done
`ifdef LFSR_LOCKUP_GUARD_EN
    ,
    output logic             o_seed_fixed
`endif
);

    localparam int SW = cnt_width(SCRAMBLE_CYCLES);
    localparam int BW = cnt_width(OUT_BITS);
    localparam logic [SW-1:0] SC_LAST  = SW'(SCRAMBLE_CYCLES == 0 ? 0 : SCRAMBLE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(OUT_BITS - 1);

    state_t           state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] load_seed;
    logic [SW-1:0]    sc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             fill_r;

`ifdef LFSR_LOCKUP_GUARD_EN
    assign load_seed = (i_seed == '0) ? '1 : i_seed;
`else
    assign load_seed = i_seed;
`endif

    // scrambling always uses feedback; streaming uses the fill mode latched at start
    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .value      (r_lfsr),
        .fill       ((state == SCRAMBLE) | fill_r),
        .next_value (lfsr_next)
    );

    assign o_out = o_valid & r_lfsr[0];

    // run sequencer with registered status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            r_lfsr  <= '0;
            sc_cnt  <= '0;
            bit_cnt <= '0;
            fill_r  <= 1'b0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
            o_seed_fixed <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
            o_seed_fixed <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_start) begin
                        r_lfsr  <= load_seed;
                        fill_r  <= i_continuous;
                        sc_cnt  <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
`ifdef LFSR_LOCKUP_GUARD_EN
                        o_seed_fixed <= (i_seed == '0);
`endif
                        if (SCRAMBLE_CYCLES == 0) begin
                            state   <= SHIFT;
                            o_valid <= 1'b1;
                        end else begin
                            state <= SCRAMBLE;
                        end
                    end
                end
                SCRAMBLE: begin
                    r_lfsr <= lfsr_next;
                    sc_cnt <= sc_cnt + 1'b1;
                    if (sc_cnt == SC_LAST) begin
                        state   <= SHIFT;
                        o_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (i_ready) begin
                        r_lfsr  <= lfsr_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= DONE;
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed checks of the LFSR stream generator with hand-computed bit streams
module tb_lfsr_stream_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] seed = 4'b0;
    logic       cont = 1'b0;
    logic       ready = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       busy_a, valid_a, out_a, done_a;
    logic       busy_b, valid_b, out_b, done_b;
    logic       busy_c, valid_c, out_c, done_c;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic       fix_a, fix_b, fix_c;
`endif
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    lfsr_stream_gen #(.WIDTH(4), .TAPS(4'b0111), .SCRAMBLE_CYCLES(8), .OUT_BITS(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_seed(seed), .i_continuous(cont),
        .o_busy(busy_a), .o_valid(valid_a), .o_out(out_a), .i_ready(ready), .o_done(done_a)
`ifdef LFSR_LOCKUP_GUARD_EN
        , .o_seed_fixed(fix_a)
`endif
    );

    lfsr_stream_gen #(.WIDTH(4), .TAPS(4'b0111), .SCRAMBLE_CYCLES(8), .OUT_BITS(6)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_seed(seed), .i_continuous(cont),
        .o_busy(busy_b), .o_valid(valid_b), .o_out(out_b), .i_ready(ready), .o_done(done_b)
`ifdef LFSR_LOCKUP_GUARD_EN
        , .o_seed_fixed(fix_b)
`endif
    );

    lfsr_stream_gen #(.WIDTH(4), .TAPS(4'b0111), .SCRAMBLE_CYCLES(0), .OUT_BITS(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_c), .i_seed(seed), .i_continuous(cont),
        .o_busy(busy_c), .o_valid(valid_c), .o_out(out_c), .i_ready(ready), .o_done(done_c)
`ifdef LFSR_LOCKUP_GUARD_EN
        , .o_seed_fixed(fix_c)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // raise start for one accept edge on the chosen instance; returns 1 time unit after that edge
    task automatic start_run(input int which, input logic [3:0] s, input logic c);
        seed = s;
        cont = c;
        start_a = (which == 0);
        start_b = (which == 1);
        start_c = (which == 2);
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++;
        if ({busy_a, valid_a, out_a, done_a} !== 4'b0000)
            $display("FAIL reset_outputs: got %b want 0000", {busy_a, valid_a, out_a, done_a});
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({busy_a, valid_a} !== 2'b00)
            $display("FAIL idle_after_reset: got %b want 00", {busy_a, valid_a});
        else passed++;
    endtask

    task automatic test_zero_fill();
        logic [3:0] exp = 4'b1100;
        ready = 1'b1;
        start_run(0, 4'b1001, 1'b0);
        total++;
        if (busy_a !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy_a);
        else passed++;
        repeat (7) tick();
        total++;
        if (valid_a !== 1'b0) $display("FAIL valid_early: got %b want 0", valid_a);
        else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({valid_a, out_a} !== {1'b1, exp[i]})
                $display("FAIL zero_fill_bit%0d: got %b want %b", i, {valid_a, out_a}, {1'b1, exp[i]});
            else passed++;
            tick();
        end
        total++;
        if ({done_a, busy_a, valid_a, out_a} !== 4'b1100)
            $display("FAIL done_pulse: got %b want 1100", {done_a, busy_a, valid_a, out_a});
        else passed++;
        tick();
        total++;
        if ({done_a, busy_a} !== 2'b00)
            $display("FAIL after_done: got %b want 00", {done_a, busy_a});
        else passed++;
    endtask

    task automatic test_continuous();
        logic [5:0] exp = 6'b011100;
        ready = 1'b1;
        start_run(1, 4'b1001, 1'b1);
        repeat (8) tick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({valid_b, out_b} !== {1'b1, exp[i]})
                $display("FAIL cont_bit%0d: got %b want %b", i, {valid_b, out_b}, {1'b1, exp[i]});
            else passed++;
            tick();
        end
        total++;
        if ({done_b, valid_b} !== 2'b10)
            $display("FAIL cont_done: got %b want 10", {done_b, valid_b});
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] exp = 4'b1100;
        logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int         b = 0;
        start_run(0, 4'b1001, 1'b0);
        repeat (8) tick();
        for (int k = 0; k < 7; k++) begin
            ready = pat[k];
            total++;
            if ({valid_a, out_a} !== {1'b1, exp[b]})
                $display("FAIL bp_cycle%0d: got %b want %b", k, {valid_a, out_a}, {1'b1, exp[b]});
            else passed++;
            tick();
            if (pat[k]) b++;
        end
        ready = 1'b1;
        total++;
        if ({done_a, valid_a} !== 2'b10)
            $display("FAIL bp_done: got %b want 10", {done_a, valid_a});
        else passed++;
        tick();
    endtask

    task automatic test_ignored_start();
        logic [3:0] exp = 4'b1100;
        start_run(0, 4'b1001, 1'b0);
        seed = 4'b0110;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({valid_a, out_a} !== {1'b1, exp[i]})
                $display("FAIL ign_bit%0d: got %b want %b", i, {valid_a, out_a}, {1'b1, exp[i]});
            else passed++;
            tick();
        end
        start_a = 1'b1;
        total++;
        if (done_a !== 1'b1) $display("FAIL ign_done: got %b want 1", done_a);
        else passed++;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy_a, valid_a} !== 2'b00)
            $display("FAIL ign_no_rerun: got %b want 00", {busy_a, valid_a});
        else passed++;
    endtask

    task automatic test_reset_mid();
        start_run(0, 4'b1001, 1'b0);
        repeat (9) tick();
        total++;
        if ({valid_a, out_a} !== 2'b10)
            $display("FAIL mid_second_bit: got %b want 10", {valid_a, out_a});
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({busy_a, valid_a, out_a, done_a} !== 4'b0000)
            $display("FAIL async_reset: got %b want 0000", {busy_a, valid_a, out_a, done_a});
        else passed++;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        total++;
        if ({busy_a, done_a} !== 2'b00)
            $display("FAIL reset_no_done: got %b want 00", {busy_a, done_a});
        else passed++;
        test_zero_fill();
    endtask

    task automatic test_no_scramble();
        logic [3:0] exp = 4'b1001;
        start_run(2, 4'b1001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({valid_c, out_c} !== {1'b1, exp[i]})
                $display("FAIL nosc_bit%0d: got %b want %b", i, {valid_c, out_c}, {1'b1, exp[i]});
            else passed++;
            tick();
        end
        total++;
        if (done_c !== 1'b1) $display("FAIL nosc_done: got %b want 1", done_c);
        else passed++;
        tick();
    endtask

    task automatic test_zero_seed();
`ifdef LFSR_LOCKUP_GUARD_EN
        logic [3:0] exp = 4'b1111;
`else
        logic [3:0] exp = 4'b0000;
`endif
        start_run(0, 4'b0000, 1'b0);
`ifdef LFSR_LOCKUP_GUARD_EN
        total++;
        if (fix_a !== 1'b1) $display("FAIL seed_fixed_high: got %b want 1", fix_a);
        else passed++;
        tick();
        total++;
        if (fix_a !== 1'b0) $display("FAIL seed_fixed_low: got %b want 0", fix_a);
        else passed++;
        repeat (7) tick();
`else
        repeat (8) tick();
`endif
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({valid_a, out_a} !== {1'b1, exp[i]})
                $display("FAIL zseed_bit%0d: got %b want %b", i, {valid_a, out_a}, {1'b1, exp[i]});
            else passed++;
            tick();
        end
        total++;
        if (done_a !== 1'b1) $display("FAIL zseed_done: got %b want 1", done_a);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_continuous();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_no_scramble();
        test_zero_seed();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
